// File: rtl/tl_ul_mem_slave.sv
// TileLink-UL backing-memory manager: a byte-maskable 64-bit word array that
// serves Get and PutFullData/PutPartialData messages of up to 64 bytes, and
// answers out-of-range, misaligned or unsupported requests with denied
// responses. One message is in flight at a time; all D outputs are registered.
module tl_ul_mem_slave #(
  parameter int                ADDR_W    = 64,
  parameter int                DATA_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
  parameter int                MEM_WORDS = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2:0]        tl_a_opcode_i,
  input  logic [2:0]        tl_a_param_i,
  input  logic [2:0]        tl_a_size_i,
  input  logic [3:0]        tl_a_source_i,
  input  logic [ADDR_W-1:0] tl_a_address_i,
  input  logic [7:0]        tl_a_mask_i,
  input  logic [DATA_W-1:0] tl_a_data_i,
  input  logic              tl_a_valid_i,
  output logic              tl_a_ready_o,
  output logic [2:0]        tl_d_opcode_o,
  output logic [1:0]        tl_d_param_o,
  output logic [2:0]        tl_d_size_o,
  output logic [3:0]        tl_d_source_o,
  output logic [1:0]        tl_d_sink_o,
  output logic              tl_d_denied_o,
  output logic [DATA_W-1:0] tl_d_data_o,
  output logic              tl_d_corrupt_o,
  output logic              tl_d_valid_o,
  input  logic              tl_d_ready_i
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] D_ACK       = 3'd0;
  localparam logic [2:0] D_ACK_DATA  = 3'd1;

  // One past the last byte served, kept one bit wider so the top of the
  // address space cannot wrap.
  localparam logic [ADDR_W:0] MEM_LIMIT =
    {1'b0, BASE_ADDR} + ((ADDR_W+1)'(MEM_WORDS) << 3);

  typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_e;

  // Index of the final beat of a message. Sizes above 64 bytes are always
  // denied and would overflow the 3-bit beat counter, so they are framed as a
  // single beat.
  function automatic logic [2:0] last_beat(input logic [2:0] size);
    case (size)
      3'd4:    return 3'd1;
      3'd5:    return 3'd3;
      3'd6:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  // Refusal decision for the first beat of a message.
  function automatic logic req_denied(input logic [2:0]        op,
                                      input logic [2:0]        size,
                                      input logic [ADDR_W-1:0] addr);
    logic [ADDR_W:0] span;
    logic [ADDR_W:0] end_addr;
    logic            bad_op;
    logic            bad_align;
    logic            bad_range;
    span      = (ADDR_W+1)'(1) << size;
    end_addr  = {1'b0, addr} + span;
    bad_op    = !(op == OP_PUT_FULL || op == OP_PUT_PART || op == OP_GET);
    bad_align = (({1'b0, addr} & (span - (ADDR_W+1)'(1))) != '0);
    bad_range = (addr < BASE_ADDR) || (end_addr > MEM_LIMIT);
    return bad_op || bad_align || bad_range || (size > 3'd6);
  endfunction

  logic [DATA_W-1:0] mem [MEM_WORDS];

  state_e            state_q, state_d;
  logic [2:0]        count_q, count_d;

  logic [2:0]        lat_size;
  logic [3:0]        lat_source;
  logic [IDX_W-1:0]  lat_idx;
  logic              lat_den;
  logic [2:0]        lat_last;
  logic              lat_en;

  logic              d_valid_q, d_valid_d;
  logic [2:0]        d_opcode_q, d_opcode_d;
  logic [2:0]        d_size_q, d_size_d;
  logic [3:0]        d_source_q, d_source_d;
  logic              d_denied_q, d_denied_d;
  logic              d_corrupt_q, d_corrupt_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  req_idx;
  logic              req_den;
  logic [2:0]        req_last;
  logic              req_get;
  logic              req_put;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;
  logic              a_fire;
  logic              d_fire;
  logic              unused_bits;

  assign off      = tl_a_address_i - BASE_ADDR;
  assign req_idx  = off[IDX_W+2:3];
  assign req_den  = req_denied(tl_a_opcode_i, tl_a_size_i, tl_a_address_i);
  assign req_last = last_beat(tl_a_size_i);
  assign req_get  = (tl_a_opcode_i == OP_GET);
  assign req_put  = (tl_a_opcode_i == OP_PUT_FULL) || (tl_a_opcode_i == OP_PUT_PART);

  assign tl_a_ready_o = !rst_i && (state_q == IDLE || state_q == WRITE);
  assign a_fire       = tl_a_valid_i && tl_a_ready_o;
  assign d_fire       = d_valid_q && tl_d_ready_i;

  // First beats address the array from the request; later beats walk from
  // the latched base index. A read prefetches the beat after the current one.
  assign rd_idx  = (state_q == IDLE) ? req_idx
                                     : lat_idx + IDX_W'(count_q) + IDX_W'(1);
  assign wr_idx  = (state_q == IDLE) ? req_idx : lat_idx + IDX_W'(count_q);
  assign rd_data = mem[rd_idx];

  assign tl_d_valid_o   = d_valid_q;
  assign tl_d_opcode_o  = d_opcode_q;
  assign tl_d_param_o   = 2'b00;
  assign tl_d_size_o    = d_size_q;
  assign tl_d_source_o  = d_source_q;
  assign tl_d_sink_o    = 2'b00;
  assign tl_d_denied_o  = d_denied_q;
  assign tl_d_corrupt_o = d_corrupt_q;
  assign tl_d_data_o    = d_data_q;

  assign unused_bits = ^{tl_a_param_i, off};

  // Next-state, beat counter and D register updates; D holds unless a beat
  // is consumed or a new response is launched.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lat_en      = 1'b0;
    mem_we      = 1'b0;
    d_valid_d   = d_valid_q;
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    d_data_d    = d_data_q;
    case (state_q)
      IDLE: begin
        if (a_fire) begin
          lat_en     = 1'b1;
          count_d    = 3'd0;
          d_size_d   = tl_a_size_i;
          d_source_d = tl_a_source_i;
          d_denied_d = req_den;
          if (req_get) begin
            state_d     = READ;
            d_valid_d   = 1'b1;
            d_opcode_d  = D_ACK_DATA;
            d_corrupt_d = req_den;
            d_data_d    = req_den ? '0 : rd_data;
          end else begin
            mem_we = req_put && !req_den;
            if (req_put && req_last != 3'd0) begin
              state_d = WRITE;
              count_d = 3'd1;
            end else begin
              state_d     = ACK;
              d_valid_d   = 1'b1;
              d_opcode_d  = D_ACK;
              d_corrupt_d = 1'b0;
              d_data_d    = '0;
            end
          end
        end
      end
      WRITE: begin
        if (a_fire) begin
          mem_we  = !lat_den;
          count_d = count_q + 3'd1;
          if (count_q == lat_last) begin
            state_d     = ACK;
            count_d     = 3'd0;
            d_valid_d   = 1'b1;
            d_opcode_d  = D_ACK;
            d_size_d    = lat_size;
            d_source_d  = lat_source;
            d_denied_d  = lat_den;
            d_corrupt_d = 1'b0;
            d_data_d    = '0;
          end
        end
      end
      READ: begin
        if (d_fire) begin
          if (count_q == lat_last) begin
            state_d   = IDLE;
            count_d   = 3'd0;
            d_valid_d = 1'b0;
          end else begin
            count_d  = count_q + 3'd1;
            d_data_d = lat_den ? '0 : rd_data;
          end
        end
      end
      ACK: begin
        if (d_fire) begin
          state_d   = IDLE;
          d_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and registered D outputs, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      count_q     <= 3'd0;
      d_valid_q   <= 1'b0;
      d_opcode_q  <= 3'd0;
      d_size_q    <= 3'd0;
      d_source_q  <= 4'd0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      d_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      d_valid_q   <= d_valid_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
      d_data_q    <= d_data_d;
    end
  end

  // Message context captured on the first A beat.
  always_ff @(posedge clk_i) begin
    if (lat_en) begin
      lat_size   <= tl_a_size_i;
      lat_source <= tl_a_source_i;
      lat_idx    <= req_idx;
      lat_den    <= req_den;
      lat_last   <= req_last;
    end
  end

  // Byte-masked array write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (tl_a_mask_i[i]) mem[wr_idx][8*i +: 8] <= tl_a_data_i[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_tl_ul_mem_slave.sv
// Directed bench for tl_ul_mem_slave: reset, single and burst Put/Get,
// partial writes, D back-pressure, denied requests and mid-burst reset.
module tb_tl_ul_mem_slave;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [2:0]  tl_a_opcode_i;
  logic [2:0]  tl_a_param_i;
  logic [2:0]  tl_a_size_i;
  logic [3:0]  tl_a_source_i;
  logic [63:0] tl_a_address_i;
  logic [7:0]  tl_a_mask_i;
  logic [63:0] tl_a_data_i;
  logic        tl_a_valid_i;
  logic        tl_a_ready_o;
  logic [2:0]  tl_d_opcode_o;
  logic [1:0]  tl_d_param_o;
  logic [2:0]  tl_d_size_o;
  logic [3:0]  tl_d_source_o;
  logic [1:0]  tl_d_sink_o;
  logic        tl_d_denied_o;
  logic [63:0] tl_d_data_o;
  logic        tl_d_corrupt_o;
  logic        tl_d_valid_o;
  logic        tl_d_ready_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tl_ul_mem_slave dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .tl_a_opcode_i  (tl_a_opcode_i),
    .tl_a_param_i   (tl_a_param_i),
    .tl_a_size_i    (tl_a_size_i),
    .tl_a_source_i  (tl_a_source_i),
    .tl_a_address_i (tl_a_address_i),
    .tl_a_mask_i    (tl_a_mask_i),
    .tl_a_data_i    (tl_a_data_i),
    .tl_a_valid_i   (tl_a_valid_i),
    .tl_a_ready_o   (tl_a_ready_o),
    .tl_d_opcode_o  (tl_d_opcode_o),
    .tl_d_param_o   (tl_d_param_o),
    .tl_d_size_o    (tl_d_size_o),
    .tl_d_source_o  (tl_d_source_o),
    .tl_d_sink_o    (tl_d_sink_o),
    .tl_d_denied_o  (tl_d_denied_o),
    .tl_d_data_o    (tl_d_data_o),
    .tl_d_corrupt_o (tl_d_corrupt_o),
    .tl_d_valid_o   (tl_d_valid_o),
    .tl_d_ready_i   (tl_d_ready_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one A beat and returns 1 time unit after the edge that took it.
  task automatic a_send(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                        input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
    int n;
    tl_a_opcode_i  = op;
    tl_a_size_i    = sz;
    tl_a_source_i  = src;
    tl_a_address_i = addr;
    tl_a_mask_i    = mask;
    tl_a_data_i    = data;
    tl_a_valid_i   = 1'b1;
    n = 0;
    while (!tl_a_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      failures++;
      $display("FAIL a_ready_timeout got=%b exp=1", tl_a_ready_o);
    end
    tick();
    tl_a_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++; if (tl_d_valid_o !== 1'b0) begin failures++; $display("FAIL rst_d_valid got=%b exp=0", tl_d_valid_o); end
    checks++; if (tl_a_ready_o !== 1'b0) begin failures++; $display("FAIL rst_a_ready got=%b exp=0", tl_a_ready_o); end
    checks++; if (tl_d_data_o !== 64'h0) begin failures++; $display("FAIL rst_d_data got=%h exp=0", tl_d_data_o); end
    checks++; if ({tl_d_opcode_o, tl_d_size_o, tl_d_source_o, tl_d_denied_o, tl_d_corrupt_o} !== 12'h0) begin
      failures++; $display("FAIL rst_d_fields got=%h exp=0", {tl_d_opcode_o, tl_d_size_o, tl_d_source_o, tl_d_denied_o, tl_d_corrupt_o});
    end
    rst_i = 1'b0;
    #1;
    checks++; if (tl_a_ready_o !== 1'b1) begin failures++; $display("FAIL post_rst_a_ready got=%b exp=1", tl_a_ready_o); end
  endtask

  task automatic test_single();
    a_send(3'd0, 3'd3, 4'd3, BASE + 64'h10, 8'hFF, 64'h1122_3344_5566_7788);
    checks++; if (tl_d_valid_o !== 1'b1 || tl_d_opcode_o !== 3'd0) begin
      failures++; $display("FAIL single_put_ack got=%b/%0d exp=1/0", tl_d_valid_o, tl_d_opcode_o);
    end
    checks++; if (tl_d_source_o !== 4'd3 || tl_d_size_o !== 3'd3 || tl_d_denied_o !== 1'b0) begin
      failures++; $display("FAIL single_put_fields got=%0d/%0d/%b exp=3/3/0", tl_d_source_o, tl_d_size_o, tl_d_denied_o);
    end
    tick();
    checks++; if (tl_d_valid_o !== 1'b0) begin failures++; $display("FAIL single_put_ack_drop got=%b exp=0", tl_d_valid_o); end
    a_send(3'd4, 3'd3, 4'd5, BASE + 64'h10, 8'h00, 64'h0);
    checks++; if (tl_d_valid_o !== 1'b1 || tl_d_opcode_o !== 3'd1) begin
      failures++; $display("FAIL single_get_beat got=%b/%0d exp=1/1", tl_d_valid_o, tl_d_opcode_o);
    end
    checks++; if (tl_d_data_o !== 64'h1122_3344_5566_7788) begin
      failures++; $display("FAIL single_get_data got=%h exp=1122334455667788", tl_d_data_o);
    end
    checks++; if (tl_d_source_o !== 4'd5 || tl_d_size_o !== 3'd3 || tl_d_denied_o !== 1'b0 || tl_d_corrupt_o !== 1'b0) begin
      failures++; $display("FAIL single_get_fields got=%0d/%0d/%b/%b exp=5/3/0/0", tl_d_source_o, tl_d_size_o, tl_d_denied_o, tl_d_corrupt_o);
    end
    tick();
    checks++; if (tl_d_valid_o !== 1'b0 || tl_a_ready_o !== 1'b1) begin
      failures++; $display("FAIL single_get_done got=%b/%b exp=0/1", tl_d_valid_o, tl_a_ready_o);
    end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 8; i++) begin
      a_send(3'd0, 3'd6, 4'd9, BASE + 64'h40, 8'hFF, 64'(i));
      if (i < 7) begin
        checks++; if (tl_d_valid_o !== 1'b0) begin failures++; $display("FAIL burst_early_ack beat=%0d got=%b exp=0", i, tl_d_valid_o); end
      end
    end
    checks++; if (tl_d_valid_o !== 1'b1 || tl_d_opcode_o !== 3'd0 || tl_d_size_o !== 3'd6 || tl_d_source_o !== 4'd9) begin
      failures++; $display("FAIL burst_put_ack got=%b/%0d/%0d/%0d exp=1/0/6/9", tl_d_valid_o, tl_d_opcode_o, tl_d_size_o, tl_d_source_o);
    end
    tick();
    a_send(3'd4, 3'd6, 4'd7, BASE + 64'h40, 8'h00, 64'h0);
    for (int k = 0; k < 8; k++) begin
      checks++; if (tl_d_valid_o !== 1'b1 || tl_d_opcode_o !== 3'd1 || tl_d_data_o !== 64'(k)) begin
        failures++; $display("FAIL burst_get beat=%0d got=%b/%0d/%h exp=1/1/%h", k, tl_d_valid_o, tl_d_opcode_o, tl_d_data_o, 64'(k));
      end
      tick();
    end
    checks++; if (tl_d_valid_o !== 1'b0) begin failures++; $display("FAIL burst_get_end got=%b exp=0", tl_d_valid_o); end
  endtask

  task automatic test_partial();
    a_send(3'd0, 3'd3, 4'd1, BASE + 64'h100, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    a_send(3'd1, 3'd3, 4'd1, BASE + 64'h100, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB);
    tick();
    a_send(3'd4, 3'd3, 4'd2, BASE + 64'h100, 8'h00, 64'h0);
    checks++; if (tl_d_data_o !== 64'hFFFF_FFFF_BBBB_BBBB) begin
      failures++; $display("FAIL partial_data got=%h exp=ffffffffbbbbbbbb", tl_d_data_o);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [2:0] pat;
    int beat;
    int cyc;
    pat  = 3'b001;
    beat = 0;
    cyc  = 0;
    a_send(3'd4, 3'd6, 4'd12, BASE + 64'h40, 8'h00, 64'h0);
    while (beat < 8 && cyc < 100) begin
      checks++; if (tl_d_valid_o !== 1'b1 || tl_d_data_o !== 64'(beat) || tl_d_source_o !== 4'd12 || tl_d_size_o !== 3'd6) begin
        failures++; $display("FAIL stall_beat beat=%0d got=%b/%h/%0d/%0d exp=1/%h/12/6", beat, tl_d_valid_o, tl_d_data_o, tl_d_source_o, tl_d_size_o, 64'(beat));
      end
      checks++; if (tl_a_ready_o !== 1'b0) begin failures++; $display("FAIL stall_a_ready beat=%0d got=%b exp=0", beat, tl_a_ready_o); end
      tl_d_ready_i = pat[cyc % 3];
      tick();
      if (pat[cyc % 3]) beat++;
      cyc++;
    end
    tl_d_ready_i = 1'b1;
    checks++; if (beat != 8) begin failures++; $display("FAIL stall_timeout got=%0d exp=8", beat); end
    checks++; if (tl_d_valid_o !== 1'b0 || tl_a_ready_o !== 1'b1) begin
      failures++; $display("FAIL stall_end got=%b/%b exp=0/1", tl_d_valid_o, tl_a_ready_o);
    end
  endtask

  task automatic test_denied();
    int n;
    a_send(3'd4, 3'd3, 4'd4, BASE - 64'h8, 8'h00, 64'h0);
    checks++; if (tl_d_valid_o !== 1'b1 || tl_d_opcode_o !== 3'd1 || tl_d_denied_o !== 1'b1 || tl_d_corrupt_o !== 1'b1 || tl_d_data_o !== 64'h0) begin
      failures++; $display("FAIL den_below got=%b/%0d/%b/%b/%h exp=1/1/1/1/0", tl_d_valid_o, tl_d_opcode_o, tl_d_denied_o, tl_d_corrupt_o, tl_d_data_o);
    end
    tick();
    a_send(3'd4, 3'd6, 4'd4, BASE + 64'h20, 8'h00, 64'h0);
    for (int k = 0; k < 8; k++) begin
      checks++; if (tl_d_valid_o !== 1'b1 || tl_d_denied_o !== 1'b1 || tl_d_corrupt_o !== 1'b1 || tl_d_data_o !== 64'h0) begin
        failures++; $display("FAIL den_misalign beat=%0d got=%b/%b/%b/%h exp=1/1/1/0", k, tl_d_valid_o, tl_d_denied_o, tl_d_corrupt_o, tl_d_data_o);
      end
      tick();
    end
    checks++; if (tl_d_valid_o !== 1'b0) begin failures++; $display("FAIL den_misalign_end got=%b exp=0", tl_d_valid_o); end
    a_send(3'd4, 3'd7, 4'd4, BASE, 8'h00, 64'h0);
    checks++; if (tl_d_valid_o !== 1'b1 || tl_d_denied_o !== 1'b1 || tl_d_corrupt_o !== 1'b1 || tl_d_data_o !== 64'h0) begin
      failures++; $display("FAIL den_size7 got=%b/%b/%b/%h exp=1/1/1/0", tl_d_valid_o, tl_d_denied_o, tl_d_corrupt_o, tl_d_data_o);
    end
    n = 0;
    while (tl_d_valid_o && n < 20) begin
      tick();
      n++;
    end
    checks++; if (n >= 20) begin failures++; $display("FAIL den_size7_drain got=%0d exp=<20", n); end
    a_send(3'd2, 3'd3, 4'd6, BASE + 64'h10, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD);
    checks++; if (tl_d_valid_o !== 1'b1 || tl_d_opcode_o !== 3'd0 || tl_d_denied_o !== 1'b1 || tl_d_corrupt_o !== 1'b0 || tl_d_source_o !== 4'd6) begin
      failures++; $display("FAIL den_opcode2 got=%b/%0d/%b/%b/%0d exp=1/0/1/0/6", tl_d_valid_o, tl_d_opcode_o, tl_d_denied_o, tl_d_corrupt_o, tl_d_source_o);
    end
    tick();
    a_send(3'd0, 3'd3, 4'd0, BASE + 64'h18, 8'hFF, 64'h5555_5555_5555_5555);
    tick();
    a_send(3'd0, 3'd4, 4'd8, BASE + 64'h18, 8'hFF, 64'hBAD0);
    a_send(3'd0, 3'd4, 4'd8, BASE + 64'h18, 8'hFF, 64'hBAD1);
    checks++; if (tl_d_valid_o !== 1'b1 || tl_d_opcode_o !== 3'd0 || tl_d_denied_o !== 1'b1 || tl_d_size_o !== 3'd4) begin
      failures++; $display("FAIL den_put_ack got=%b/%0d/%b/%0d exp=1/0/1/4", tl_d_valid_o, tl_d_opcode_o, tl_d_denied_o, tl_d_size_o);
    end
    tick();
    a_send(3'd4, 3'd3, 4'd0, BASE + 64'h18, 8'h00, 64'h0);
    checks++; if (tl_d_data_o !== 64'h5555_5555_5555_5555) begin failures++; $display("FAIL den_put_nowrite got=%h exp=5555555555555555", tl_d_data_o); end
    tick();
    a_send(3'd4, 3'd3, 4'd0, BASE + 64'h10, 8'h00, 64'h0);
    checks++; if (tl_d_data_o !== 64'h1122_3344_5566_7788) begin failures++; $display("FAIL den_op2_nowrite got=%h exp=1122334455667788", tl_d_data_o); end
    tick();
    a_send(3'd0, 3'd3, 4'd0, BASE + 64'h7FF8, 8'hFF, 64'h0123_4567_89AB_CDEF);
    checks++; if (tl_d_denied_o !== 1'b0) begin failures++; $display("FAIL top_word_put_denied got=%b exp=0", tl_d_denied_o); end
    tick();
    a_send(3'd4, 3'd3, 4'd0, BASE + 64'h7FF8, 8'h00, 64'h0);
    checks++; if (tl_d_data_o !== 64'h0123_4567_89AB_CDEF || tl_d_denied_o !== 1'b0) begin
      failures++; $display("FAIL top_word_get got=%h/%b exp=0123456789abcdef/0", tl_d_data_o, tl_d_denied_o);
    end
    tick();
    a_send(3'd4, 3'd3, 4'd0, BASE + 64'h8000, 8'h00, 64'h0);
    checks++; if (tl_d_denied_o !== 1'b1 || tl_d_data_o !== 64'h0) begin
      failures++; $display("FAIL den_above got=%b/%h exp=1/0", tl_d_denied_o, tl_d_data_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    a_send(3'd4, 3'd6, 4'd10, BASE + 64'h40, 8'h00, 64'h0);
    tick();
    tick();
    tick();
    checks++; if (tl_d_data_o !== 64'h3) begin failures++; $display("FAIL mid_beat3 got=%h exp=3", tl_d_data_o); end
    rst_i = 1'b1;
    tick();
    checks++; if (tl_d_valid_o !== 1'b0 || tl_d_data_o !== 64'h0 || tl_a_ready_o !== 1'b0) begin
      failures++; $display("FAIL mid_rst got=%b/%h/%b exp=0/0/0", tl_d_valid_o, tl_d_data_o, tl_a_ready_o);
    end
    rst_i = 1'b0;
    #1;
    checks++; if (tl_a_ready_o !== 1'b1) begin failures++; $display("FAIL mid_rst_idle got=%b exp=1", tl_a_ready_o); end
    a_send(3'd4, 3'd3, 4'd11, BASE + 64'h10, 8'h00, 64'h0);
    checks++; if (tl_d_valid_o !== 1'b1 || tl_d_data_o !== 64'h1122_3344_5566_7788 || tl_d_source_o !== 4'd11) begin
      failures++; $display("FAIL mid_after_get got=%b/%h/%0d exp=1/1122334455667788/11", tl_d_valid_o, tl_d_data_o, tl_d_source_o);
    end
    tick();
    checks++; if (tl_d_valid_o !== 1'b0) begin failures++; $display("FAIL mid_after_end got=%b exp=0", tl_d_valid_o); end
  endtask

  initial begin
    rst_i          = 1'b1;
    tl_a_opcode_i  = 3'd0;
    tl_a_param_i   = 3'd0;
    tl_a_size_i    = 3'd0;
    tl_a_source_i  = 4'd0;
    tl_a_address_i = 64'h0;
    tl_a_mask_i    = 8'h0;
    tl_a_data_i    = 64'h0;
    tl_a_valid_i   = 1'b0;
    tl_d_ready_i   = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_partial();
    test_stall();
    test_denied();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_ul_mem_slave.md
# tl_ul_mem_slave

Backing-memory TileLink-UL manager sitting directly downstream of the L2 cache's memory port: it consumes the L2's `mem_a_*` request stream and produces the `mem_d_*` response stream. It holds a byte-maskable word array and serves Get and PutFullData/PutPartialData bursts of up to 64 bytes. Out-of-range, misaligned or unsupported requests get denied responses.

## Interface
- `ADDR_W`, 64: address width.
- `DATA_W`, 64: beat width; fixed at 64 (8 mask bits).
- `BASE_ADDR`, 64'h8000_0000: first byte address served.
- `MEM_WORDS`, 4096: number of 64-bit words in the array (power of two).
- `clk_i` in 1: single clock, all logic on rising edge.
- `rst_i` in 1: reset; synchronous, active-high.
- `tl_a_opcode_i` in 3: 0 PutFullData, 1 PutPartialData, 4 Get; others unsupported.
- `tl_a_param_i` in 3: ignored.
- `tl_a_size_i` in 3: log2 bytes.
- `tl_a_source_i` in 4: request ID, echoed on D.
- `tl_a_address_i` in ADDR_W: byte address.
- `tl_a_mask_i` in 8: byte lanes for Put beats.
- `tl_a_data_i` in DATA_W: Put beat data.
- `tl_a_valid_i` in 1, `tl_a_ready_o` out 1: A handshake.
- `tl_d_opcode_o` out 3: 0 AccessAck, 1 AccessAckData.
- `tl_d_param_o` out 2: always 0.
- `tl_d_size_o` out 3: echo of request size.
- `tl_d_source_o` out 4: echo of request source.
- `tl_d_sink_o` out 2: always 0.
- `tl_d_denied_o` out 1: request refused.
- `tl_d_data_o` out DATA_W: read beat.
- `tl_d_corrupt_o` out 1: equals denied on AccessAckData, 0 on AccessAck.
- `tl_d_valid_o` out 1, `tl_d_ready_i` in 1: D handshake.

## Operation
- Beats per message: `nbeats = (size <= 3) ? 1 : 2^(size-3)`; size 6 = 8 beats. Beat counter 3 bits.
- Denied if any: size > 6; address not aligned to 2^size; `addr < BASE_ADDR` or `addr + 2^size > BASE_ADDR + MEM_WORDS*8`; unsupported opcode. Evaluated on the first A beat, latched for the whole message.
- Word index = `(addr - BASE_ADDR) >> 3`, plus beat count within a burst.
- FSM states: IDLE, WRITE, READ, ACK.
  - IDLE: `tl_a_ready_o=1`. On Get handshake latch opcode/size/source/address/denied and go to READ. On Put handshake write beat 0, then go to ACK if nbeats==1, else WRITE with count=1. On unsupported opcode, consume the single beat and go to ACK (denied).
  - WRITE: `tl_a_ready_o=1`. Each handshake writes beat `count` and increments count. After the last beat, go to ACK. Beats inside a burst use the latched size/source/address; their address field is ignored.
  - READ: `tl_d_valid_o=1`, AccessAckData. Data = `array[idx+count]`, or 0 if denied. Each D handshake increments count. After the last beat handshake, go to IDLE.
  - ACK: one AccessAck beat. On handshake go to IDLE.
- Writes: byte lanes with `mask[i]=1` are updated; PutFullData uses the mask too. Denied Puts write nothing but still consume every beat.
- `tl_a_ready_o` is 0 in READ and ACK. Only one message is in flight at a time.

## Timing
- All D outputs are registered. Array read is asynchronous, captured into the D data register.
- Get accepted at cycle t: beat 0 valid at t+1. With `tl_d_ready_i` held high, beat k is valid at t+1+k. An 8-beat read is complete at t+8.
- Last Put beat accepted at t: AccessAck valid at t+1.
- The next A handshake is possible in the cycle after the final D handshake.
- While `tl_d_valid_o=1 && !tl_d_ready_i`, all `tl_d_*` outputs hold stable.
- Reset (any state, mid-burst included): at the next edge go to IDLE with count=0 and every output 0 except `tl_a_ready_o=0` in the reset cycle and 1 afterwards. Array contents are not reset. Any partially written burst keeps the beats already written.
- Back-to-back: a Put written at t and a Get of the same word accepted later returns the new data.

## Test plan
- Get size 3 at `BASE_ADDR+0x10` after Put size 3 data `0x1122334455667788` mask 0xFF → one AccessAckData at t+1 with that data, size 3, source echoed, denied 0.
- PutFullData size 6 at `BASE_ADDR+0x40`, beats `0x0..0x7` → one AccessAck one cycle after beat 7. Then Get size 6 → 8 AccessAckData beats 0..7 in order, one per cycle.
- PutPartialData mask 0x0F data `0xAAAAAAAA_BBBBBBBB` over word `0xFFFF..FF` → readback `0xFFFFFFFF_BBBBBBBB`.
- Get size 6 while `tl_d_ready_i` toggles 1,0,0,1… → data and `tl_d_valid_o` stay stable during stalls; 8 beats delivered; `tl_a_ready_o` stays 0 until the last handshake.
- Get at `BASE_ADDR - 8`, Get size 6 at `BASE_ADDR+0x20` (misaligned), Get size 7, opcode 2 → responses denied=1: Gets return data 0 with corrupt=1; opcode 2 returns AccessAck with corrupt=0. No array change.
- Assert `rst_i` during beat 3 of an 8-beat read → next cycle `tl_d_valid_o=0`, FSM in IDLE. After reset, a new Get size 3 completes normally.
